// File: rtl/zeroheti_addr_demux.sv
// zeroHETI data-port address demultiplexer: runtime base/last regions, in-order response tracking.
// Optional error responder for unmapped addresses enabled by `define ZEROHETI_DEMUX_ERR_RESP_EN.
module zeroheti_addr_demux #(
    parameter int unsigned NumRules       = 2,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumRules*AddrWidth-1:0] rule_base_i,
    input  logic [NumRules*AddrWidth-1:0] rule_last_i,
    input  logic                          req_i,
    output logic                          gnt_o,
    input  logic [AddrWidth-1:0]          addr_i,
    input  logic                          we_i,
    input  logic [DataWidth/8-1:0]        be_i,
    input  logic [DataWidth-1:0]          wdata_i,
    output logic                          rvalid_o,
    output logic [DataWidth-1:0]          rdata_o,
    output logic                          err_o,
    output logic [NumRules-1:0]           sub_req_o,
    input  logic [NumRules-1:0]           sub_gnt_i,
    output logic [AddrWidth-1:0]          sub_addr_o,
    output logic                          sub_we_o,
    output logic [DataWidth/8-1:0]        sub_be_o,
    output logic [DataWidth-1:0]          sub_wdata_o,
    input  logic [NumRules-1:0]           sub_rvalid_i,
    input  logic [NumRules*DataWidth-1:0] sub_rdata_i,
    input  logic [NumRules-1:0]           sub_err_i
);

    localparam int unsigned SelW = $clog2(NumRules + 1);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

`ifdef ZEROHETI_DEMUX_ERR_RESP_EN
    localparam logic [SelW-1:0] ErrSel     = SelW'(NumRules);
    localparam logic [SelW-1:0] DefaultSel = ErrSel;
`else
    localparam logic [SelW-1:0] DefaultSel = SelW'(NumRules - 1);
`endif

    logic [SelW-1:0]      w_sel;
    logic                 w_allow;
    logic                 w_tgt_gnt;
    logic                 w_hs;
    logic                 w_resp_v;
    logic                 w_resp;
    logic [DataWidth-1:0] w_resp_data;
    logic                 w_resp_err;
    logic [CntW-1:0]      w_cnt_eff;

    logic [CntW-1:0]      r_cnt;
    logic [SelW-1:0]      r_last_sel;
`ifdef ZEROHETI_DEMUX_ERR_RESP_EN
    logic                 r_err_pend;
`endif

    // Address decode: scan downwards so the lowest hitting rule has the final say.
    always_comb begin
        w_sel = DefaultSel;
        for (int k = NumRules - 1; k >= 0; k--) begin
            if ((addr_i >= rule_base_i[k*AddrWidth +: AddrWidth]) &&
                (addr_i <  rule_last_i[k*AddrWidth +: AddrWidth])) begin
                w_sel = SelW'(k);
            end else begin
                w_sel = w_sel;
            end
        end
    end

    // Response source: the port that owns the outstanding transactions.
    always_comb begin
        w_resp_v    = 1'b0;
        w_resp_data = {DataWidth{1'b0}};
        w_resp_err  = 1'b0;
        for (int k = 0; k < NumRules; k++) begin
            if (r_last_sel == SelW'(k)) begin
                w_resp_v    = sub_rvalid_i[k];
                w_resp_data = sub_rdata_i[k*DataWidth +: DataWidth];
                w_resp_err  = sub_err_i[k];
            end else begin
                w_resp_v    = w_resp_v;
            end
        end
`ifdef ZEROHETI_DEMUX_ERR_RESP_EN
        if (r_last_sel == ErrSel) begin
            w_resp_v    = r_err_pend;
            w_resp_data = {DataWidth{1'b0}};
            w_resp_err  = 1'b1;
        end else begin
            w_resp_v    = w_resp_v;
        end
`endif
    end

    assign w_resp = w_resp_v & (r_cnt != {CntW{1'b0}});

    // A response retiring this cycle frees its slot immediately, so a stalled or target-switching
    // request can issue in the same cycle the blocking response returns.
    assign w_cnt_eff = r_cnt - CntW'(w_resp);
    assign w_allow   = (w_cnt_eff == {CntW{1'b0}}) ||
                       ((w_sel == r_last_sel) && (w_cnt_eff < CntW'(MaxOutstanding)));

    // Request steering and selection of the target's grant.
    always_comb begin
        sub_req_o = {NumRules{1'b0}};
        w_tgt_gnt = 1'b0;
        for (int k = 0; k < NumRules; k++) begin
            if (w_sel == SelW'(k)) begin
                sub_req_o[k] = req_i & w_allow;
                w_tgt_gnt    = sub_gnt_i[k];
            end else begin
                sub_req_o[k] = 1'b0;
            end
        end
`ifdef ZEROHETI_DEMUX_ERR_RESP_EN
        if (w_sel == ErrSel) begin
            w_tgt_gnt = req_i;
        end else begin
            w_tgt_gnt = w_tgt_gnt;
        end
`endif
    end

    assign gnt_o = w_tgt_gnt & w_allow;
    assign w_hs  = req_i & gnt_o;

    assign rvalid_o = w_resp;
    assign rdata_o  = w_resp ? w_resp_data : {DataWidth{1'b0}};
    assign err_o    = w_resp & w_resp_err;

    assign sub_addr_o  = addr_i;
    assign sub_we_o    = we_i;
    assign sub_be_o    = be_i;
    assign sub_wdata_o = wdata_i;

    // Outstanding-transaction bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt      <= {CntW{1'b0}};
            r_last_sel <= {SelW{1'b0}};
`ifdef ZEROHETI_DEMUX_ERR_RESP_EN
            r_err_pend <= 1'b0;
`endif
        end else begin
            r_cnt <= r_cnt + CntW'(w_hs) - CntW'(w_resp);
            if (w_hs) begin
                r_last_sel <= w_sel;
            end else begin
                r_last_sel <= r_last_sel;
            end
`ifdef ZEROHETI_DEMUX_ERR_RESP_EN
            r_err_pend <= w_hs & (w_sel == ErrSel);
`endif
        end
    end

endmodule

// File: doc/zeroheti_addr_demux.md
# zeroheti_addr_demux

Parametrised address demultiplexer between the zeroHETI core's data port and its memory-mapped subordinates (CLIC, RAM, peripherals). Successor to the fixed single-rule address map: decodes against `NumRules` runtime-programmable base/last regions, routes each request to one subordinate port, and tracks up to `MaxOutstanding` in-flight transactions so responses return in order to the correct source. Unmapped accesses are optionally absorbed by an internal error responder.

## Interface
- `NumRules`, 2: number of address regions and subordinate ports (1..16)
- `MaxOutstanding`, 4: in-flight transaction limit (1..15)
- `AddrWidth`, 32: address width
- `DataWidth`, 32: data width
- `clk_i` in 1: clock
- `rst_i` in 1: reset, synchronous, active-high
- `rule_base_i` in `NumRules*AddrWidth`: region base per rule, inclusive (rule k at bits [k*AddrWidth +: AddrWidth])
- `rule_last_i` in `NumRules*AddrWidth`: region end per rule, exclusive
- `req_i` in 1: host request valid
- `gnt_o` out 1: host request accepted
- `addr_i` in `AddrWidth`, `we_i` in 1, `be_i` in `DataWidth/8`, `wdata_i` in `DataWidth`: host request payload
- `rvalid_o` out 1, `rdata_o` out `DataWidth`, `err_o` out 1: host response
- `sub_req_o` out `NumRules`: per-port request, at most one bit set
- `sub_gnt_i` in `NumRules`: per-port grant
- `sub_addr_o`, `sub_we_o`, `sub_be_o`, `sub_wdata_o` out: payload broadcast to all ports
- `sub_rvalid_i` in `NumRules`, `sub_rdata_i` in `NumRules*DataWidth`, `sub_err_i` in `NumRules`: per-port response

## Operation
- Decode (combinational): rule k hits when `base_k <= addr_i < last_k`, unsigned. Lowest hitting index wins. Rule with `last <= base` never hits. No hit selects target ERR (index `NumRules`).
- State: `cnt` (outstanding count, `$clog2(MaxOutstanding+1)` bits), `last_sel` (target of the outstanding transactions), `err_pend` (1 bit).
- Admission: request may issue if `cnt == 0`, or if `sel == last_sel` and `cnt < MaxOutstanding`. Otherwise `sub_req_o = 0` and `gnt_o = 0` (stall; host holds payload).
- Issue: `sub_req_o[sel] = req_i & allow`; `gnt_o = sub_gnt_i[sel] & allow`. Handshake loads `last_sel <= sel`.
- `cnt`: +1 on handshake, -1 on accepted response, unchanged when both occur in the same cycle. Never exceeds `MaxOutstanding`, never underflows.
- Response routing: `rvalid_o = sub_rvalid_i[last_sel] & (cnt != 0)`; `rdata_o`/`err_o` from the same port. Responses arriving while `cnt == 0` are dropped.
- `rdata_o = 0` whenever `rvalid_o = 0`.

## Timing
- Request path combinational: grant visible in the cycle the subordinate grants.
- Response path combinational from `sub_rvalid_i`; no added latency.
- Error responder: grants immediately; `rvalid_o=1`, `err_o=1`, `rdata_o=0` exactly one cycle after the grant. Back-to-back errors yield one response per cycle.
- Target switch: earliest new-target issue is the cycle in which the last old response returns.
- Reset values: `cnt=0`, `last_sel=0`, `err_pend=0`; hence `gnt_o=0`, `rvalid_o=0`, `err_o=0`, `rdata_o=0`, `sub_req_o=0` unless `req_i` is asserted.
- Reset mid-transaction discards all outstanding state. Late subordinate responses are dropped by the `cnt == 0` gate.

## Configuration
- `ZEROHETI_DEMUX_ERR_RESP_EN` defined: error responder and ERR target present as described.
- Not defined: no error responder; unmapped addresses route to port `NumRules-1` (default port), and `err_o` comes solely from `sub_err_i`.

## Test plan
- Rules {0x0000–0x8000, 0x9000–0xA000}; read 0x9004, port 1 grants same cycle, `rvalid` next cycle with 0xCAFE -> `sub_req_o=2'b10`, `gnt_o=1`, `rdata_o=0xCAFE`, `err_o=0`.
- Four back-to-back reads to port 0 with responses withheld (`MaxOutstanding=4`) -> 4 grants; fifth request stalled with `gnt_o=0` until first `rvalid`, then granted that same cycle.
- Read port 0 outstanding, then request 0x9000 -> `sub_req_o=0` until port-0 response; port 1 issued in the cycle of that response; responses arrive in order.
- Access 0xF000 with macro defined -> immediate `gnt_o`, next cycle `rvalid_o=1`, `err_o=1`, `rdata_o=0`, no `sub_req_o`. Without macro -> `sub_req_o[1]=1`.
- Overlapping rules {0x0–0x10000, 0x9000–0xA000}, access 0x9000 -> port 0 selected.
- Two outstanding, assert `rst_i` one cycle, then late `sub_rvalid_i[0]` -> `rvalid_o=0`, `cnt=0`; next request issues normally.
